// File: rtl/lite_cmd_load_dispatch_if.sv
// Stream-in and buffer write-port bundle for lite_cmd_load_dispatch.
// slave: the dispatcher's view; master: the PS/DMA + buffer side.
interface lite_cmd_load_dispatch_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic              buf_wr_ready;
  logic              buf_wr_en;
  logic [3:0]        buf_wr_sel;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, buf_wr_ready,
    output s_axis_tready, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, buf_wr_ready,
    input  s_axis_tready, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data
  );
endinterface

// File: rtl/lite_cmd_load_dispatch.sv
// Command front end: decodes start edges from lite_reg0, steers MM2S beats
// into the selected buffer, forwards conv / write-back starts and reports
// completion with a single task_finish pulse.
// Optional: define LOAD_BEAT_CHECK_EN to compare load beats against
// lite_reg1[31:16] and raise the sticky load_err flag.
module lite_cmd_load_dispatch #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic [31:0] lite_reg0,
  input  logic [31:0] lite_reg1,
  input  logic [31:0] lite_reg2,
  lite_cmd_load_dispatch_if.slave bus,
  output logic        conv_start,
  input  logic        conv_done,
  output logic        wb_start,
  input  logic        wb_done,
  output logic [7:0]  cfg_batch,
  output logic [31:0] cfg_layer,
  output logic        task_finish,
  output logic        load_err
);

  typedef enum logic [2:0] {IDLE, LOAD, CONV, WB, FIN} state_t;
  state_t state, state_n;

  logic [2:0]        cmd_q, cmd_qq, cmd_rise;
  logic [3:0]        tgt_q, tgt_sel;
  logic              load_go, conv_go, wb_go;
  logic              hs, beat_end, last_pend;
  logic [ADDR_W-1:0] addr_cnt;
  logic              unused_bits;

  assign unused_bits = ^{lite_reg0[31:8], lite_reg0[3], lite_reg1[15:8]};

  // Target code to one-hot buffer select; zero means "not a load target".
  always_comb begin
    tgt_sel = 4'b0000;
    case (tgt_q)
      4'h2:    tgt_sel = 4'b0001;
      4'h3:    tgt_sel = 4'b0010;
      4'h5:    tgt_sel = 4'b0100;
      4'h4:    tgt_sel = 4'b1000;
      default: tgt_sel = 4'b0000;
    endcase
  end

  // Edges only count in IDLE; priority load > conv > write-back. A load
  // with a bad target is dropped and does not shadow the other edges.
  assign cmd_rise = cmd_q & ~cmd_qq;
  assign load_go  = (state == IDLE) && cmd_rise[0] && (tgt_sel != 4'b0000);
  assign conv_go  = (state == IDLE) && !load_go && cmd_rise[2];
  assign wb_go    = (state == IDLE) && !load_go && !cmd_rise[2] && cmd_rise[1];

  // last_pend blocks tready for the one cycle the final write is in flight.
  assign bus.s_axis_tready = (state == LOAD) && !last_pend && bus.buf_wr_ready;
  assign hs = bus.s_axis_tvalid && bus.s_axis_tready;

`ifdef LOAD_BEAT_CHECK_EN
  logic [LEN_W-1:0] exp_len, beat_cnt;
  logic             len_chk, len_hit;

  assign len_chk  = (exp_len != '0);
  assign len_hit  = len_chk && ((beat_cnt + LEN_W'(1)) == exp_len);
  assign beat_end = bus.s_axis_tlast || len_hit;

  // Beat counter and sticky length error; cleared by the next load start.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      exp_len  <= '0;
      beat_cnt <= '0;
      load_err <= 1'b0;
    end else if (load_go) begin
      exp_len  <= LEN_W'(lite_reg1[31:16]);
      beat_cnt <= '0;
      load_err <= 1'b0;
    end else if (hs) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
      if (len_chk && (bus.s_axis_tlast != len_hit)) load_err <= 1'b1;
    end
  end
`else
  logic [LEN_W-1:0] unused_len;

  assign unused_len = LEN_W'(lite_reg1[31:16]);
  assign beat_end   = bus.s_axis_tlast;
  assign load_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (load_go)      state_n = LOAD;
        else if (conv_go) state_n = CONV;
        else if (wb_go)   state_n = WB;
      end
      LOAD:    if (last_pend) state_n = FIN;
      CONV:    if (conv_done) state_n = FIN;
      WB:      if (wb_done)   state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command sampling, write path, start pulses and config latches.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cmd_q           <= '0;
      cmd_qq          <= '0;
      tgt_q           <= '0;
      conv_start      <= 1'b0;
      wb_start        <= 1'b0;
      task_finish     <= 1'b0;
      last_pend       <= 1'b0;
      addr_cnt        <= '0;
      cfg_batch       <= '0;
      cfg_layer       <= '0;
      bus.buf_wr_en   <= 1'b0;
      bus.buf_wr_sel  <= '0;
      bus.buf_wr_addr <= '0;
      bus.buf_wr_data <= '0;
    end else begin
      cmd_q         <= lite_reg0[2:0];
      cmd_qq        <= cmd_q;
      tgt_q         <= lite_reg0[7:4];
      conv_start    <= conv_go;
      wb_start      <= wb_go;
      task_finish   <= (state_n == FIN);
      last_pend     <= hs && beat_end;
      bus.buf_wr_en <= hs;
      if (hs) begin
        bus.buf_wr_data <= bus.s_axis_tdata;
        bus.buf_wr_addr <= addr_cnt;
        addr_cnt        <= addr_cnt + ADDR_W'(1);
      end
      if (load_go) begin
        bus.buf_wr_sel <= tgt_sel;
        addr_cnt       <= '0;
        cfg_layer      <= lite_reg2;
      end
      if (conv_go) begin
        cfg_batch <= lite_reg1[7:0];
        cfg_layer <= lite_reg2;
      end
      if (wb_go) cfg_layer <= lite_reg2;
      if (state == FIN) bus.buf_wr_sel <= '0;
    end
  end

endmodule
